sram_like_axi_bridge: RTL and testbench

// Memory-side responder for the sram-like port driven by the data cache: accepts cache_data_req,

---
 rtl/sram_like_axi_bridge_pkg.sv | 38 +++
 rtl/sram_like_axi_bridge_if.sv | 86 ++++++++
 rtl/sram_axi_wstrb_gen.sv | 20 ++
 rtl/sram_like_axi_bridge.sv | 140 ++++++++++++++
 tb/tb_sram_like_axi_bridge.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_axi_bridge_pkg.sv
// Shared definitions for the sram-like to AXI bridge: FSM states, AXI field encodings and
// the sram-like size to AXI size mapping.
package sram_like_axi_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdAr,
        StRdR,
        StWrAwW,
        StWrB
    } state_e;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    localparam logic [1:0] AxiBurstIncr = 2'b01;
    localparam logic [2:0] AxiSize1     = 3'b000;
    localparam logic [2:0] AxiSize2     = 3'b001;
    localparam logic [2:0] AxiSize4     = 3'b010;

    localparam logic [1:0] AxiRespOkay   = 2'b00;
    localparam logic [1:0] AxiRespExOkay = 2'b01;
    localparam logic [1:0] AxiRespSlvErr = 2'b10;
    localparam logic [1:0] AxiRespDecErr = 2'b11;

    // Size code 3 is treated as a word access.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        logic [2:0] result;
        unique case (size)
            SizeByte: result = AxiSize1;
            SizeHalf: result = AxiSize2;
            default:  result = AxiSize4;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sram_like_axi_bridge_if.sv
// Bundle of the sram-like request port and the single-beat AXI master channels.
// master: the bridge view; slave: the cache + interconnect view.
interface sram_like_axi_bridge_if #(
    parameter int unsigned IdWidth = 4
) ();
    logic                 data_req;
    logic                 data_wr;
    logic [1:0]           data_size;
    logic [31:0]          data_addr;
    logic [31:0]          data_wdata;
    logic [31:0]          data_rdata;
    logic                 data_addr_ok;
    logic                 data_data_ok;

    logic [IdWidth-1:0]   arid;
    logic [31:0]          araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic [1:0]           arlock;
    logic [3:0]           arcache;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;

    logic [IdWidth-1:0]   rid;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    logic [IdWidth-1:0]   awid;
    logic [31:0]          awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic [1:0]           awlock;
    logic [3:0]           awcache;
    logic [2:0]           awprot;
    logic                 awvalid;
    logic                 awready;

    logic [IdWidth-1:0]   wid;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;

    logic [IdWidth-1:0]   bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    modport master (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_axi_wstrb_gen.sv
// Byte-lane strobe for a single sram-like store, from access size and the low address bits.
// Shared with the instruction-side bridge.
module sram_axi_wstrb_gen
    import sram_like_axi_bridge_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_wstrb
);

    always_comb begin
        o_wstrb = 4'b1111;
        unique case (i_size)
            SizeByte: o_wstrb = 4'b0001 << i_addr_lo;
            SizeHalf: o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            default:  o_wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/sram_like_axi_bridge.sv
// Data-side sram-like responder: each accepted request becomes one single-beat AXI transfer,
// with one transaction outstanding at a time.
module sram_like_axi_bridge
    import sram_like_axi_bridge_pkg::*;
#(
    parameter int unsigned IdWidth = 4,
    parameter int unsigned AxiId   = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    sram_like_axi_bridge_if.master        io_bus
);

    state_e      r_state;
    state_e      w_state_next;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_aw_done;
    logic        r_w_done;
    logic        w_aw_done_next;
    logic        w_w_done_next;
    logic        w_aw_fin;
    logic        w_w_fin;
    logic        w_addr_ok;
    logic [3:0]  w_wstrb;
    logic        w_unused_axi;

    assign w_addr_ok = io_bus.data_req & (r_state == StIdle);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_size    <= 2'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_aw_done <= w_aw_done_next;
            r_w_done  <= w_w_done_next;
            if (w_addr_ok) begin
                r_size  <= io_bus.data_size;
                r_addr  <= io_bus.data_addr;
                r_wdata <= io_bus.data_wdata;
            end
        end
    end

    // Each channel is finished once it has handshaken, either earlier or in this cycle.
    assign w_aw_fin = r_aw_done | io_bus.awready;
    assign w_w_fin  = r_w_done | io_bus.wready;

    always_comb begin
        w_state_next        = r_state;
        w_aw_done_next      = 1'b0;
        w_w_done_next       = 1'b0;
        io_bus.arvalid      = 1'b0;
        io_bus.rready       = 1'b0;
        io_bus.awvalid      = 1'b0;
        io_bus.wvalid       = 1'b0;
        io_bus.bready       = 1'b0;
        io_bus.data_data_ok = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (io_bus.data_req) begin
                    w_state_next = io_bus.data_wr ? StWrAwW : StRdAr;
                end
            end
            StRdAr: begin
                io_bus.arvalid = 1'b1;
                if (io_bus.arready) begin
                    w_state_next = StRdR;
                end
            end
            StRdR: begin
                io_bus.rready = 1'b1;
                if (io_bus.rvalid) begin
                    io_bus.data_data_ok = 1'b1;
                    w_state_next        = StIdle;
                end
            end
            StWrAwW: begin
                io_bus.awvalid = ~r_aw_done;
                io_bus.wvalid  = ~r_w_done;
                if (w_aw_fin && w_w_fin) begin
                    w_state_next = StWrB;
                end else begin
                    w_aw_done_next = w_aw_fin;
                    w_w_done_next  = w_w_fin;
                end
            end
            StWrB: begin
                io_bus.bready = 1'b1;
                if (io_bus.bvalid) begin
                    io_bus.data_data_ok = 1'b1;
                    w_state_next        = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    sram_axi_wstrb_gen u_wstrb_gen (
        .i_size    (r_size),
        .i_addr_lo (r_addr[1:0]),
        .o_wstrb   (w_wstrb)
    );

    assign io_bus.data_addr_ok = w_addr_ok;
    assign io_bus.data_rdata   = io_bus.rdata;

    assign io_bus.arid    = IdWidth'(AxiId);
    assign io_bus.araddr  = r_addr;
    assign io_bus.arlen   = 8'd0;
    assign io_bus.arsize  = axi_size(r_size);
    assign io_bus.arburst = AxiBurstIncr;
    assign io_bus.arlock  = 2'b00;
    assign io_bus.arcache = 4'd0;
    assign io_bus.arprot  = 3'd0;

    assign io_bus.awid    = IdWidth'(AxiId);
    assign io_bus.awaddr  = r_addr;
    assign io_bus.awlen   = 8'd0;
    assign io_bus.awsize  = axi_size(r_size);
    assign io_bus.awburst = AxiBurstIncr;
    assign io_bus.awlock  = 2'b00;
    assign io_bus.awcache = 4'd0;
    assign io_bus.awprot  = 3'd0;

    assign io_bus.wid     = IdWidth'(AxiId);
    assign io_bus.wdata   = r_wdata;
    assign io_bus.wstrb   = w_wstrb;
    assign io_bus.wlast   = 1'b1;

    // Response status and IDs are deliberately ignored; errors complete like OKAY.
    assign w_unused_axi = ^{io_bus.rid, io_bus.rresp, io_bus.rlast, io_bus.bid, io_bus.bresp};

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Bench for sram_like_axi_bridge: directed and randomized transactions against a memory
// reference model and per-cycle channel expectations derived from ready/valid delays.
module tb_sram_like_axi_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_like_axi_bridge_if #(.IdWidth(4)) bus ();

    sram_like_axi_bridge #(
        .IdWidth (4),
        .AxiId   (0)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] slave_mem [16];
    logic [31:0] ref_mem   [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_size  = 2'd0;
        bus.data_addr  = 32'd0;
        bus.data_wdata = 32'd0;
        bus.arready    = 1'b0;
        bus.rvalid     = 1'b0;
        bus.rdata      = $urandom;
        bus.rid        = 4'($urandom);
        bus.rresp      = 2'($urandom);
        bus.rlast      = 1'b1;
        bus.awready    = 1'b0;
        bus.wready     = 1'b0;
        bus.bvalid     = 1'b0;
        bus.bid        = 4'($urandom);
        bus.bresp      = 2'($urandom);
    endtask

    function automatic logic [6:0] ctl_vec();
        return {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
                bus.data_data_ok, bus.data_addr_ok};
    endfunction

    // One request from the cache side; d_a = AR/AW ready delay, d_w = W ready delay,
    // d_r = R/B valid delay after the address phase(s) complete.
    task automatic txn(input string name, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int d_a, input int d_w, input int d_r, input bit hammer,
                       output logic [31:0] rd_obs);
        int nbytes, base, mx, exp_done, done_c, a_hs_c, w_hs_c, both_c, viol, a_cnt, w_cnt;
        int a_idx;
        logic [3:0]  exp_strb, strb_cap;
        logic [2:0]  exp_size;
        logic [31:0] exp_rd, wdata_cap;
        logic [5:0]  exp_vec, obs_vec;
        nbytes   = (size == 2'd3) ? 4 : (1 << size);
        base     = int'(addr[1:0]) / nbytes * nbytes;
        exp_strb = 4'd0;
        for (int b = 0; b < 4; b++) if (b >= base && b < base + nbytes) exp_strb[b] = 1'b1;
        exp_size = (nbytes == 1) ? 3'd0 : (nbytes == 2) ? 3'd1 : 3'd2;
        mx       = (d_a > d_w) ? d_a : d_w;
        exp_done = wr ? (2 + mx + d_r) : (2 + d_a + d_r);
        exp_rd   = ref_mem[addr[5:2]];
        done_c = -1; a_hs_c = -1; w_hs_c = -1; both_c = -1;
        viol = 0; a_cnt = 0; w_cnt = 0; a_idx = 0;
        strb_cap = 4'd0; wdata_cap = 32'd0; rd_obs = 32'd0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            drive_idle();
            if (c == 0) begin
                bus.data_req   = 1'b1;
                bus.data_wr    = wr;
                bus.data_size  = size;
                bus.data_addr  = addr;
                bus.data_wdata = wdata;
            end else if (hammer) begin
                bus.data_req   = 1'b1;
                bus.data_wr    = 1'($urandom);
                bus.data_size  = 2'($urandom);
                bus.data_addr  = $urandom;
                bus.data_wdata = $urandom;
            end
            bus.arready = !wr && (c >= 1 + d_a);
            bus.awready = wr && (c >= 1 + d_a);
            bus.wready  = wr && (c >= 1 + d_w);
            bus.rvalid  = !wr && (a_hs_c >= 0) && (c >= a_hs_c + 1 + d_r);
            if (bus.rvalid) bus.rdata = slave_mem[a_idx];
            bus.bvalid  = wr && (both_c >= 0) && (c >= both_c + 1 + d_r);
            #1;
            exp_vec = {c == 0,
                       !wr && c >= 1 && c <= 1 + d_a,
                       !wr && c >= 2 + d_a && c <= exp_done,
                       wr && c >= 1 && c <= 1 + d_a,
                       wr && c >= 1 && c <= 1 + d_w,
                       wr && c >= 2 + mx && c <= exp_done};
            obs_vec = {bus.data_addr_ok, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid,
                       bus.bready};
            if (obs_vec !== exp_vec) viol++;
            if (bus.arvalid === 1'b1) begin
                a_cnt++;
                if (bus.araddr !== addr || bus.arsize !== exp_size ||
                    {bus.arlen, bus.arburst, bus.arlock, bus.arcache, bus.arprot, bus.arid}
                    !== {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd0}) viol++;
                if (bus.arready && a_hs_c < 0) begin
                    a_hs_c = c;
                    a_idx  = int'(bus.araddr[5:2]);
                end
            end
            if (bus.awvalid === 1'b1) begin
                a_cnt++;
                if (bus.awaddr !== addr || bus.awsize !== exp_size ||
                    {bus.awlen, bus.awburst, bus.awlock, bus.awcache, bus.awprot, bus.awid}
                    !== {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd0}) viol++;
                if (bus.awready && a_hs_c < 0) begin
                    a_hs_c = c;
                    a_idx  = int'(bus.awaddr[5:2]);
                end
            end
            if (bus.wvalid === 1'b1) begin
                w_cnt++;
                if (bus.wdata !== wdata || bus.wstrb !== exp_strb || bus.wlast !== 1'b1 ||
                    bus.wid !== 4'd0) viol++;
                if (bus.wready && w_hs_c < 0) begin
                    w_hs_c    = c;
                    strb_cap  = bus.wstrb;
                    wdata_cap = bus.wdata;
                end
            end
            if (wr && both_c < 0 && a_hs_c >= 0 && w_hs_c >= 0) begin
                both_c = c;
                for (int b = 0; b < 4; b++)
                    if (strb_cap[b]) slave_mem[a_idx][b*8 +: 8] = wdata_cap[b*8 +: 8];
            end
            if (bus.data_data_ok === 1'b1) begin
                done_c = c;
                rd_obs = bus.data_rdata;
                break;
            end
        end
        chk({name, "_latency"}, done_c, exp_done);
        chk({name, "_channel_cycles"}, viol, 0);
        chk({name, "_addr_valid_cycles"}, a_cnt, d_a + 1);
        if (wr) begin
            chk({name, "_wvalid_cycles"}, w_cnt, d_w + 1);
            for (int b = 0; b < 4; b++)
                if (exp_strb[b]) ref_mem[addr[5:2]][b*8 +: 8] = wdata[b*8 +: 8];
        end else begin
            chk({name, "_rdata"}, rd_obs, exp_rd);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        rwr;
        logic [1:0]  rsize;
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        slave_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4]   = 32'hDEAD_BEEF;

        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_outputs", 32'(ctl_vec()), 32'd0);

        // Word read with immediate responses.
        txn("rd_word", 1'b0, 2'd2, 32'h1FC0_0010, 32'd0, 0, 0, 0, 1'b0, rd);
        chk("rd_word_value", rd, 32'hDEAD_BEEF);

        // Byte store to lane 3, W accepted three cycles after AW.
        txn("sb_lane3", 1'b1, 2'd0, 32'h8000_0003, 32'hAA00_0000, 0, 3, 0, 1'b0, rd);
        txn("sb_readback", 1'b0, 2'd2, 32'h8000_0000, 32'd0, 0, 0, 0, 1'b0, rd);
        chk("sb_readback_byte", {24'd0, rd[31:24]}, 32'h0000_00AA);

        txn("sh_upper", 1'b1, 2'd1, 32'h0000_0022, 32'h1234_5678, 1, 0, 2, 1'b0, rd);
        txn("rd_size3", 1'b0, 2'd3, 32'h0000_0020, 32'd0, 0, 0, 1, 1'b0, rd);

        // Slow AR with the cache re-requesting the whole time.
        txn("ar_stall", 1'b0, 2'd2, 32'h0000_0014, 32'd0, 5, 0, 0, 1'b1, rd);

        // Write immediately followed by a read.
        txn("b2b_wr", 1'b1, 2'd2, 32'h0000_0030, 32'hCAFE_F00D, 0, 0, 0, 1'b1, rd);
        txn("b2b_rd", 1'b0, 2'd2, 32'h0000_0030, 32'd0, 0, 0, 0, 1'b0, rd);
        chk("b2b_rd_value", rd, 32'hCAFE_F00D);

        // Reset while waiting for R.
        @(posedge clk); #1;
        drive_idle(); bus.data_req = 1'b1; bus.data_addr = 32'h0000_0008; bus.data_size = 2'd2;
        @(posedge clk); #1;
        drive_idle(); bus.arready = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        #1;
        chk("pre_rst_rready", 32'(bus.rready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_in_rd_r", 32'(ctl_vec()), 32'd0);
        txn("after_rst_rd", 1'b0, 2'd2, 32'h0000_0008, 32'd0, 0, 0, 0, 1'b0, rd);

        // Reset after AW has completed but W has not.
        @(posedge clk); #1;
        drive_idle(); bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = 32'h0000_000C;
        @(posedge clk); #1;
        drive_idle(); bus.awready = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        #1;
        chk("pre_rst_aw_w", 32'({bus.awvalid, bus.wvalid}), 32'b01);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_in_wr_aw_w", 32'(ctl_vec()), 32'd0);
        txn("after_rst_wr", 1'b1, 2'd2, 32'h0000_000C, 32'h0BAD_F00D, 0, 2, 0, 1'b0, rd);

        for (int i = 0; i < 40; i++) begin
            rwr   = 1'($urandom);
            rsize = 2'($urandom);
            txn($sformatf("rand%0d", i), rwr, rsize, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 1'($urandom), rd);
        end

        @(posedge clk); #1;
        drive_idle();
        #1;
        chk("final_idle", 32'(ctl_vec()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
